// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice width, sequencer state encoding, add/sub control
// encoding and the signed-overflow helper used on the last slice.
package alu_pkg;

    localparam int ALU_SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // ctrl_sub encoding
    localparam logic CTRL_ADD = 1'b0;
    localparam logic CTRL_SUB = 1'b1;

    // Two's-complement overflow: operands agree in sign but the sum does not.
    // b_msb is the sign of the operand actually fed to the adder (already
    // inverted for subtraction).
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/carry_lookahead_8bit.sv
// 8-bit carry-lookahead adder slice. Every carry is formed directly from the
// generate/propagate terms and cin rather than rippled bit to bit; group
// generate/propagate are exported so a sequencer can chain slices.
module carry_lookahead_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       gout,
    output logic       pout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       grp_g;

    assign g = a & b;
    assign p = a ^ b;

    // Flattened lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        logic gt;
        logic pp;
        c     = '0;
        grp_g = 1'b0;
        c[0]  = cin;
        for (int i = 0; i < 8; i++) begin
            gt = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gt = gt | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = gt | (pp & cin);
            if (i == 7) grp_g = gt;
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];
    assign gout = grp_g;
    assign pout = &p;

endmodule

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract built on a single shared 8-bit CLA slice.
// Operands are latched on the input handshake, then one byte per cycle (LSB
// first) passes through the slice with the carry held in a register between
// cycles. The result, carry-out and signed overflow are held on the output
// handshake until consumed.
module cla_slice_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / ALU_SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH % ALU_SLICE_W) != 0 || WIDTH == 0) begin : g_bad_width
            $error("cla_slice_sequencer: WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             cout_q, ovf_q;

    logic             accept;
    logic             last_slice;
    logic [7:0]       sl_a, sl_b, sl_s;
    logic             sl_cout, sl_g, sl_p;

    assign accept     = in_valid && (state_q == IDLE);
    assign last_slice = (state_q == RUN) && (idx_q == LAST_IDX);

    // Byte mux: select the current slice of each latched operand
    assign sl_a = a_q[int'(idx_q)*ALU_SLICE_W +: ALU_SLICE_W];
    assign sl_b = b_q[int'(idx_q)*ALU_SLICE_W +: ALU_SLICE_W];

    carry_lookahead_8bit u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_s),
        .cout (sl_cout),
        .gout (sl_g),
        .pout (sl_p)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, per-slice datapath, carry chaining and final flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry
            a_q     <= data_operandA;
            b_q     <= data_operandB ^ {WIDTH{ctrl_sub}};
            carry_q <= ctrl_sub;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            result_q[int'(idx_q)*ALU_SLICE_W +: ALU_SLICE_W] <= sl_s;
            carry_q <= sl_g | (sl_p & carry_q);
            if (last_slice) begin
                cout_q <= sl_cout;
                ovf_q  <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sl_s[7]);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign data_result = result_q;
    assign carry_out   = cout_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Bench for cla_slice_sequencer: a vector table plus random operations go
// through a scoreboard queue, followed by hand-written backpressure and
// mid-operation reset sequences.
module tb_cla_slice_sequencer;

    localparam int W      = 32;
    localparam int NSLICE = W / 8;
    localparam int BOUND  = 50;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic         ctrl_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] data_result;
    logic         carry_out;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } vec_t;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];

    always #5 clock = ~clock;

    cla_slice_sequencer #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .ctrl_sub     (ctrl_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_result  (data_result),
        .carry_out    (carry_out),
        .overflow     (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic for random vectors
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
        e.r  = full[W-1:0];
        e.c  = full[W];
        e.v  = (a[W-1] == bb[W-1]) && (e.r[W-1] != a[W-1]);
        return e;
    endfunction

    // Present one operation; push its expected result when the handshake fires
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input exp_t e);
        int n;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < BOUND) begin
            @(negedge clock);
            n++;
        end
        if (n >= BOUND) begin
            checks++; errors++;
            $display("FAIL send_timeout got in_ready=0 expected in_ready=1");
        end
        data_operandA = a; data_operandB = b; ctrl_sub = sub; in_valid = 1'b1;
        @(posedge clock);
        sb.push_back(e);
        #1 in_valid = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom; ctrl_sub = $urandom_range(0, 1);
    endtask

    // Wait for the result, check latency and value, then consume it
    task automatic collect(input string name);
        int   lat;
        exp_t e;
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end while (!out_valid && lat < BOUND);
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s_timeout got out_valid=0 expected out_valid=1", name);
            return;
        end
        check({name, "_latency"}, 64'(lat), 64'(NSLICE));
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard got empty expected entry", name);
            return;
        end
        e = sb.pop_front();
        check({name, "_result"}, 64'(data_result), 64'(e.r));
        check({name, "_carry"}, 64'(carry_out), 64'(e.c));
        check({name, "_ovf"}, 64'(overflow), 64'(e.v));
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        check({name, "_idle_ready"}, 64'(in_ready), 64'd1);
        check({name, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] held_r;
        logic         held_c, held_v;

        tbl[0] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[3] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[4] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[5] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[6] = '{32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b0};
        tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[8] = '{32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[9] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_result", 64'(data_result), 64'd0);
        check("rst_carry", 64'(carry_out), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            e = '{tbl[i].r, tbl[i].c, tbl[i].v};
            send(tbl[i].a, tbl[i].b, tbl[i].sub, e);
            collect($sformatf("vec%0d", i));
        end

        // Random operations against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
            send(ra, rb, rs, model(ra, rb, rs));
            collect($sformatf("rnd%0d", i));
        end

        // Backpressure: result held, new requests ignored while DONE
        send(32'h00010000, 32'h0000FFFF, 1'b0, '{32'h0001FFFF, 1'b0, 1'b0});
        for (int i = 0; i < NSLICE; i++) @(posedge clock);
        @(negedge clock);
        check("bp_valid_rise", 64'(out_valid), 64'd1);
        held_r = 32'h0001FFFF; held_c = 1'b0; held_v = 1'b0;
        data_operandA = 32'hDEADBEEF; data_operandB = 32'h12345678; ctrl_sub = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check($sformatf("bp_valid%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_ready%0d", i), 64'(in_ready), 64'd0);
            check($sformatf("bp_result%0d", i), 64'(data_result), 64'(held_r));
            check($sformatf("bp_flags%0d", i), 64'({carry_out, overflow}), 64'({held_c, held_v}));
        end
        in_valid = 1'b0;
        void'(sb.pop_front());
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        check("bp_after_ready", 64'(in_ready), 64'd1);
        check("bp_after_valid", 64'(out_valid), 64'd0);
        // The ignored operands must not have started anything
        @(negedge clock);
        check("bp_no_start", 64'(in_ready), 64'd1);

        // Reset during slice 2 discards the op
        send(32'h11111111, 32'h22222222, 1'b0, '{32'h33333333, 1'b0, 1'b0});
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_result", 64'(data_result), 64'd0);
        void'(sb.pop_front());
        @(negedge clock);
        reset_n = 1'b1;
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '{32'hFFFFFFFE, 1'b1, 1'b0});
        collect("post_rst");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule
